// File: rtl/rom_stream_reader_if.sv
// 32-bit single-cycle memory bus shared by boot ROM and L2 banks.
// Reads return rdata the cycle after csn is low.
interface UNICAD_MEM_BUS_32;
  logic        csn;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] add;
  logic [31:0] rdata;

  modport Master (
    output csn,
    output wen,
    output be,
    output wdata,
    output add,
    input  rdata
  );

  modport Slave (
    input  csn,
    input  wen,
    input  be,
    input  wdata,
    input  add,
    output rdata
  );
endinterface

// File: rtl/rom_stream_reader.sv
// Sequential word reader: memory bus reads into a 2-entry buffer,
// delivered in order on a valid/ready stream with a last marker.
module rom_stream_reader #(
  parameter int MAX_WORDS_WIDTH = 16,
  parameter int FIFO_DEPTH      = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic [31:0]                start_addr_i,
  input  logic [MAX_WORDS_WIDTH-1:0] num_words_i,
  output logic                       busy_o,
  output logic                       done_o,
  UNICAD_MEM_BUS_32.Master           mem_master,
  output logic [31:0]                data_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic                       last_o
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic                       csn_q, csn_d;
  logic [31:0]                add_q, add_d;
  logic [MAX_WORDS_WIDTH-1:0] rem_q, rem_d;
  logic [MAX_WORDS_WIDTH-1:0] rem_after;
  logic                       rvalid_q, rlast_q;

  logic [31:0] fifo_data [FIFO_DEPTH];
  logic        fifo_last [FIFO_DEPTH];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  cnt_q;

  logic       pop;
  logic       accept;
  logic       more;
  logic [2:0] occ_after;
  logic [2:0] occ_next;

  assign valid_o   = cnt_q != 2'd0;
  assign pop       = valid_o & ready_i;
  assign data_o    = fifo_data[rd_ptr];
  assign last_o    = valid_o & fifo_last[rd_ptr];
  assign busy_o    = state_q != IDLE;
  assign done_o    = state_q == DONE;

  // A presented read only counts if its word is sure to fit;
  // otherwise it is repeated at the same address next cycle.
  assign occ_after = {1'b0, cnt_q} + {2'b0, rvalid_q} - {2'b0, pop};
  assign accept    = ~csn_q & (occ_after < 3'd2);
  assign occ_next  = occ_after + {2'b0, accept};
  assign rem_after = rem_q - {{(MAX_WORDS_WIDTH-1){1'b0}}, accept};
  assign more      = rem_after != '0;

  assign mem_master.csn   = csn_q;
  assign mem_master.add   = add_q;
  assign mem_master.wen   = 1'b1;
  assign mem_master.be    = 4'hF;
  assign mem_master.wdata = 32'h0;

  always_comb begin
    state_d = state_q;
    csn_d   = 1'b1;
    add_d   = accept ? add_q + 32'd4 : add_q;
    rem_d   = rem_after;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (num_words_i != '0) begin
            state_d = ISSUE;
            csn_d   = 1'b0;
            add_d   = {start_addr_i[31:2], 2'b00};
            rem_d   = num_words_i;
          end else begin
            state_d = DONE;
          end
        end
      end
      ISSUE: begin
        if (!more) begin
          state_d = DRAIN;
        end else begin
          // At a full window, present only if the consumer is taking data.
          csn_d = !((occ_next < 3'd2) ||
                    ((occ_next == 3'd2) && ready_i));
        end
      end
      DRAIN: begin
        if (pop && last_o) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      csn_q    <= 1'b1;
      add_q    <= 32'h0;
      rem_q    <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      csn_q    <= csn_d;
      add_q    <= add_d;
      rem_q    <= rem_d;
      rvalid_q <= accept;
      rlast_q  <= accept && (rem_q == {{(MAX_WORDS_WIDTH-1){1'b0}}, 1'b1});
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= 32'h0;
        fifo_last[i] <= 1'b0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (rvalid_q) begin
        fifo_data[wr_ptr] <= mem_master.rdata;
        fifo_last[wr_ptr] <= rlast_q;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt_q <= cnt_q + {1'b0, rvalid_q} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader: queue model of the read window plus
// hand-computed cycle expectations for the basic and zero-length cases.
module tb_rom_stream_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] start_addr;
  logic [15:0] num_words;
  logic        busy_o;
  logic        done_o;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready;
  logic        last_o;

  UNICAD_MEM_BUS_32 mem ();

  rom_stream_reader #(
    .MAX_WORDS_WIDTH(16),
    .FIFO_DEPTH(2)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .start_i(start),
    .start_addr_i(start_addr),
    .num_words_i(num_words),
    .busy_o(busy_o),
    .done_o(done_o),
    .mem_master(mem),
    .data_o(data_o),
    .valid_o(valid_o),
    .ready_i(ready),
    .last_o(last_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-cycle ROM whose contents equal the word address.
  initial mem.rdata = 32'h0;
  always @(posedge clk) begin
    if (!mem.csn) mem.rdata <= mem.add;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  // Model: every read that fits the 2-word window is queued with its
  // expected data; the newest one is still on the bus for a cycle.
  logic [31:0] exp_q [$];
  bit          expl_q [$];
  bit          pend_m;
  bit          busy_m;
  bit          done_m;
  bit          ready_prev;
  logic [31:0] exp_addr;
  int          rem_m;
  int          delivered;
  int          done_cnt;
  int          nadd;
  logic [31:0] first_add [2];

  always @(negedge clk) begin
    int vis;
    bit pop, acc, dn, idle;
    if (!rst_n) begin
      exp_q.delete();
      expl_q.delete();
      pend_m     = 0;
      busy_m     = 0;
      done_m     = 0;
      rem_m      = 0;
      ready_prev = 0;
      chk1("rst_csn", mem.csn, 1'b1);
      chk1("rst_valid", valid_o, 1'b0);
      chk1("rst_last", last_o, 1'b0);
      chk1("rst_busy", busy_o, 1'b0);
      chk1("rst_done", done_o, 1'b0);
      chk("rst_data", data_o, 32'h0);
      chk("rst_add", mem.add, 32'h0);
    end else begin
      vis = int'(exp_q.size()) - int'(pend_m);
      chk1("busy", busy_o, busy_m);
      chk1("done", done_o, done_m);
      chk1("valid", valid_o, vis > 0);
      chk1("wen", mem.wen, 1'b1);
      chk("be", 32'(mem.be), 32'hF);
      chk("wdata", mem.wdata, 32'h0);
      if (vis > 0) begin
        chk("data", data_o, exp_q[0]);
        chk1("last", last_o, expl_q[0]);
      end
      pop = (vis > 0) && ready;
      acc = 0;
      if (!mem.csn) begin
        chk1("issue_legal", rem_m > 0, 1'b1);
        chk("add", mem.add, exp_addr);
        chk1("no_issue_full", exp_q.size() == 2 && !ready_prev, 1'b0);
        acc = (int'(exp_q.size()) - int'(pop)) < 2;
        if (nadd < 2) begin
          first_add[nadd] = mem.add;
          nadd++;
        end
      end
      if (done_o) done_cnt++;
      dn   = 0;
      idle = !busy_m;
      if (pop) begin
        if (expl_q[0]) dn = 1;
        void'(exp_q.pop_front());
        void'(expl_q.pop_front());
        delivered++;
      end
      if (acc) begin
        exp_q.push_back(exp_addr);
        expl_q.push_back(rem_m == 1);
        exp_addr = exp_addr + 32'd4;
        rem_m--;
      end
      pend_m = acc;
      if (done_m) busy_m = 0;
      if (idle && start) begin
        busy_m   = 1;
        exp_addr = {start_addr[31:2], 2'b00};
        rem_m    = int'(num_words);
        dn       = (num_words == 16'd0);
      end
      done_m     = dn;
      ready_prev = ready;
    end
  end

  task automatic basic_test();
    bit iss, vld;
    @(posedge clk); #1;
    start = 1; start_addr = 32'h1000; num_words = 16'd4; ready = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      iss = (k >= 1) && (k <= 4);
      vld = (k >= 3) && (k <= 6);
      chk1("b_csn", mem.csn, !iss);
      if (iss) chk("b_add", mem.add, 32'h1000 + 32'(4 * (k - 1)));
      chk1("b_valid", valid_o, vld);
      if (vld) begin
        chk("b_data", data_o, 32'h1000 + 32'(4 * (k - 3)));
        chk1("b_last", last_o, k == 6);
      end
      chk1("b_done", done_o, k == 7);
      chk1("b_busy", busy_o, (k >= 1) && (k <= 7));
      @(posedge clk); #1;
      start = 0;
    end
  endtask

  task automatic zero_test();
    @(posedge clk); #1;
    start = 1; start_addr = 32'h5000; num_words = 16'd0; ready = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1("z_busy", busy_o, k == 1);
      chk1("z_done", done_o, k == 1);
      chk1("z_csn", mem.csn, 1'b1);
      chk1("z_valid", valid_o, 1'b0);
      @(posedge clk); #1;
      start = 0;
    end
  endtask

  // mode 0: ready high; 1: stalled cycles 3-10 then random;
  // 2: a second start to 0x2000 arrives while busy.
  task automatic xfer(input logic [31:0] a, input int n, input int mode);
    int k;
    bit seen;
    delivered = 0;
    done_cnt  = 0;
    nadd      = 0;
    @(posedge clk); #1;
    start = 1; start_addr = a; num_words = 16'(n); ready = 1;
    k    = 0;
    seen = 0;
    while (!seen && k < 400) begin
      @(negedge clk);
      if (done_o) seen = 1;
      @(posedge clk); #1;
      k++;
      start      = (mode == 2) && (k == 2);
      start_addr = 32'h2000;
      num_words  = 16'd4;
      if (mode == 1)
        ready = (k < 3) ? 1'b1 : (k <= 10) ? 1'b0 : 1'(($urandom_range(0, 1)));
      else
        ready = 1'b1;
    end
    chk1("x_finished", seen, 1'b1);
    @(negedge clk);
    chk1("x_idle", busy_o, 1'b0);
    chk("x_delivered", 32'(delivered), 32'(n));
    chk("x_done_pulses", 32'(done_cnt), 32'd1);
  endtask

  task automatic reset_test();
    @(posedge clk); #1;
    start = 1; start_addr = 32'h6000; num_words = 16'd8; ready = 1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk1("r_third_issue", mem.csn, 1'b0);
    done_cnt = 0;
    rst_n = 0;
    #1;
    chk1("r_csn_now", mem.csn, 1'b1);
    chk1("r_valid_now", valid_o, 1'b0);
    chk1("r_busy_now", busy_o, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("r_no_done", 32'(done_cnt), 32'd0);
  endtask

  initial begin
    rst_n = 0; start = 0; start_addr = 32'h0; num_words = 16'd0; ready = 1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    basic_test();
    xfer(32'h4000, 8, 1);
    zero_test();
    xfer(32'h3000, 4, 2);
    xfer(32'h1003, 1, 0);
    chk("unaligned_add", first_add[0], 32'h1000);
    xfer(32'hFFFF_FFFC, 2, 0);
    chk("wrap_add0", first_add[0], 32'hFFFF_FFFC);
    chk("wrap_add1", first_add[1], 32'h0);
    reset_test();
    xfer(32'h7000, 2, 0);
    chk("post_rst_first", first_add[0], 32'h7000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rom_stream_reader.md
# rom_stream_reader

Bus initiator for the SoC's 32-bit single-cycle memory slaves (boot ROM, L2 banks) on `UNICAD_MEM_BUS_32`. Given a start address and word count, it issues sequential word reads, captures the returned data one cycle later and delivers it in order on a valid/ready stream with a last-word marker. It feeds boot-time copy and streaming consumers without a core in the loop, and holds at most two words in flight plus buffered, so back-pressure never loses data.

## Interface
- `MAX_WORDS_WIDTH`, default 16: width of the word-count input; max transfer is 2^16−1 words.
- `FIFO_DEPTH`, default 2: output buffer entries; fixed at 2, other values unsupported.
- `clk_i`  in  1  single clock; all state is on its rising edge.
- `rst_ni`  in  1  reset, asynchronous assert, active-low; synchronously released upstream.
- `start_i`  in  1  one-cycle request; sampled only in IDLE.
- `start_addr_i`  in  32  byte address of the first word; bits [1:0] ignored and forced to 0.
- `num_words_i`  in  MAX_WORDS_WIDTH  number of words to read; 0 is legal.
- `busy_o`  out  1  transfer in progress.
- `done_o`  out  1  one-cycle completion pulse.
- `mem_master`  `UNICAD_MEM_BUS_32.Master`  memory port:
  - `csn`: active-low select.
  - `wen`: always 1, read.
  - `be`: always 4'hF.
  - `wdata`: always 0.
  - `add`: 32-bit byte address.
  - `rdata`: valid the cycle after `csn` is low.
- `data_o`  out  32  stream data.
- `valid_o`  out  1  stream valid.
- `ready_i`  in  1  stream ready.
- `last_o`  out  1  qualifies the final word of the transfer; meaningful only with `valid_o`.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - `start_i`=1 with `num_words_i`>0: latch the address (bits [1:0]=0) and the count, then go to ISSUE.
  - `start_i`=1 with `num_words_i`=0: go directly to DONE.
- ISSUE:
  - A read is issued in a cycle when `fifo_count + inflight − pop < 2`, where `pop = valid_o & ready_i` and `inflight` is the read issued in the previous cycle (0 or 1).
  - An issue drives `csn`=0 and `add`=current address.
  - After each issue the address increments by 4 (32-bit wrap, no error) and the remaining count decrements.
  - After the final issue, go to DRAIN.
- Response: `rdata` is pushed into the FIFO on the cycle after each issue. FIFO order equals issue order.
- DRAIN: go to DONE once the last word handshakes (`valid_o & ready_i & last_o`).
- DONE: `done_o`=1 for exactly one cycle, then return to IDLE.
- `last_o` is tagged on the entry holding the word for the final issued address.
- `start_i` outside IDLE is ignored; no queuing.
- `ready_i` may toggle freely. `valid_o`, once high, holds with stable `data_o` and `last_o` until the handshake.
- Reset asserted mid-transfer:
  - All state clears immediately and `csn` goes to 1 asynchronously.
  - FIFO contents and any in-flight response are discarded.
  - No `done_o` pulse is generated.

## Timing
- Reset values: state=IDLE, `csn`=1, `wen`=1, `be`=4'hF, `wdata`=0, `add`=0, `valid_o`=0, `last_o`=0, `data_o`=0, `busy_o`=0, `done_o`=0.
- `csn` and `add` are registered outputs.
- With `start_i` at cycle 0:
  - First `csn`=0 is at cycle 1.
  - `rdata` is sampled at the end of cycle 2.
  - `valid_o` rises at cycle 3.
- Throughput is 1 word/cycle with `ready_i` held high.
- `busy_o` is high from cycle 1 through the DONE cycle inclusive.
- `done_o` rises the cycle after the last-word handshake.
- For `num_words_i`=0: `busy_o` and `done_o` are both high in cycle 1 only, and `csn` never goes low.
- Buffer capacity is 2. When `ready_i`=0 persists, issue stops with FIFO full and nothing in flight, so no overflow occurs under any `ready_i` pattern.

## Test plan
- **Basic transfer:** start at cycle 0, addr 0x0000_1000, 4 words, `ready_i`=1, ROM model returns `add`.
  - `csn`=0 in cycles 1–4 with `add` 0x1000, 0x1004, 0x1008, 0x100C.
  - `valid_o` in cycles 3–6 with data equal to those addresses; `last_o` in cycle 6.
  - `done_o` in cycle 7; `busy_o` low in cycle 8.
- **Back-pressure:** 8 words with `ready_i`=0 in cycles 3–10, then random toggling.
  - Never more than 2 words buffered plus in flight; no `csn`=0 while full.
  - All 8 words delivered in order, exactly once, with `last_o` only on the 8th.
- **Zero-length request:** `num_words_i`=0.
  - `done_o` and `busy_o` high in cycle 1 only; no `csn`=0 at any time; `valid_o` stays 0.
- **Start while busy:** second `start_i` with addr 0x2000 during a 4-word transfer.
  - Ignored: no address ≥0x2000 is issued; exactly one `done_o` pulse.
- **Unaligned start and wrap:**
  - Addr 0x0000_1003 → first `add` is 0x1000.
  - Addr 0xFFFF_FFFC, 2 words → `add` 0xFFFF_FFFC then 0x0000_0000.
- **Reset mid-transfer:** assert `rst_ni`=0 during the 3rd issue.
  - `csn`=1 and `valid_o`=0 immediately; no `done_o`.
  - After release, a new 2-word transfer completes normally.
